btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/tamagotchi_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/btn_conditioner.sv | 139 +++++++++++++
 tb/tb_btn_conditioner.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared tamagotchi definitions: default timing constants, button
// indices and the long-press hold FSM state encoding.
package tamagotchi_pkg;

    // 10 ms debounce and 1 s tick at 50 MHz, fire after 5 s
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_TICKS_PER_SEC   = 50000000;
    localparam int DEF_HOLD_SECONDS    = 5;

    // Position of each pushbutton in the conditioner's internal vectors
    localparam int IDX_SALUD     = 0;
    localparam int IDX_ENERGIA   = 1;
    localparam int IDX_HAMBRE    = 2;
    localparam int IDX_DIVERSION = 3;
    localparam int IDX_RESET     = 4;
    localparam int IDX_TEST      = 5;
    localparam int NUM_BTNS      = 6;

    typedef enum logic [1:0] {
        HOLD_IDLE    = 2'd0,
        HOLD_HOLDING = 2'd1,
        HOLD_FIRED   = 2'd2
    } hold_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer for one pushbutton.
// Ports: clk, rst_n, i_raw (async button), o_level (debounced), o_rise (1-clk pulse).
module btn_debounce
    import tamagotchi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            // Counter tracks the run of samples disagreeing with the level
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the six tamagotchi pushbuttons: press pulses for care buttons,
// long-press pulses and held-second counts for reset/test.
// Ports: clk, rst_n, raw_* (async buttons), btn_* (1-clk pulses),
// count_reset/count_test (whole seconds held, saturating at 7).
module btn_conditioner
    import tamagotchi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICKS_PER_SEC   = DEF_TICKS_PER_SEC,
    parameter int HOLD_SECONDS    = DEF_HOLD_SECONDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_salud,
    input  logic       raw_energia,
    input  logic       raw_hambre,
    input  logic       raw_diversion,
    input  logic       raw_reset,
    input  logic       raw_test,
    output logic       btn_salud,
    output logic       btn_energia,
    output logic       btn_hambre,
    output logic       btn_diversion,
    output logic       btn_reset,
    output logic       btn_test,
    output logic [2:0] count_reset,
    output logic [2:0] count_test
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [2:0]    CNT_FIRE  = 3'(HOLD_SECONDS - 1);

    logic [NUM_BTNS-1:0] w_raw;
    logic [NUM_BTNS-1:0] w_lvl;
    logic [NUM_BTNS-1:0] w_rise;
    logic                w_mask;
    logic [3:0]          r_care;

    assign w_raw = {raw_test, raw_reset, raw_diversion,
                    raw_hambre, raw_energia, raw_salud};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (w_raw[i]),
            .o_level(w_lvl[i]),
            .o_rise (w_rise[i])
        );
    end

    // Care presses are ignored while a long-press button is down
    assign w_mask = w_lvl[IDX_RESET] | w_lvl[IDX_TEST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_care <= '0;
        end else begin
            r_care <= w_rise[3:0] & {4{~w_mask}};
        end
    end

    // h = 0 handles reset, h = 1 handles test
    for (genvar h = 0; h < 2; h++) begin : g_hold
        hold_state_t   r_state;
        logic [TW-1:0] r_tick;
        logic [2:0]    r_count;
        logic          r_fire;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= HOLD_IDLE;
                r_tick  <= '0;
                r_count <= '0;
                r_fire  <= 1'b0;
            end else begin
                r_fire <= 1'b0;
                unique case (r_state)
                    HOLD_IDLE: begin
                        if (w_rise[IDX_RESET+h]) begin
                            r_state <= HOLD_HOLDING;
                            r_tick  <= '0;
                            r_count <= '0;
                        end
                    end
                    HOLD_HOLDING: begin
                        if (!w_lvl[IDX_RESET+h]) begin
                            r_state <= HOLD_IDLE;
                            r_tick  <= '0;
                            r_count <= '0;
                        end else if (r_tick == TICK_LAST) begin
                            r_tick  <= '0;
                            r_count <= r_count + 3'd1;
                            if (r_count == CNT_FIRE) begin
                                r_state <= HOLD_FIRED;
                                r_fire  <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    HOLD_FIRED: begin
                        if (!w_lvl[IDX_RESET+h]) begin
                            r_state <= HOLD_IDLE;
                            r_tick  <= '0;
                            r_count <= '0;
                        end else if (r_tick == TICK_LAST) begin
                            r_tick <= '0;
                            if (r_count != 3'd7) begin
                                r_count <= r_count + 3'd1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= HOLD_IDLE;
                        r_tick  <= '0;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_salud     = r_care[IDX_SALUD];
    assign btn_energia   = r_care[IDX_ENERGIA];
    assign btn_hambre    = r_care[IDX_HAMBRE];
    assign btn_diversion = r_care[IDX_DIVERSION];
    // Reset wins when both long presses fire together
    assign btn_reset     = g_hold[0].r_fire;
    assign btn_test      = g_hold[1].r_fire & ~g_hold[0].r_fire;
    assign count_reset   = g_hold[0].r_count;
    assign count_test    = g_hold[1].r_count;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/tick settings.
// Ports: none (top-level testbench).
module tb_btn_conditioner;
    import tamagotchi_pkg::*;

    localparam int DEB  = 4;
    localparam int TPS  = 10;
    localparam int HOLD = 5;
    localparam int BIG  = 1 << 30;
    localparam int HN   = 4096;

    logic       clk;
    logic       rst_n;
    logic [5:0] raw;
    logic       btn_salud, btn_energia, btn_hambre, btn_diversion;
    logic       btn_reset, btn_test;
    logic [2:0] count_reset, count_test;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TICKS_PER_SEC  (TPS),
        .HOLD_SECONDS   (HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_salud    (raw[0]),
        .raw_energia  (raw[1]),
        .raw_hambre   (raw[2]),
        .raw_diversion(raw[3]),
        .raw_reset    (raw[4]),
        .raw_test     (raw[5]),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_reset    (btn_reset),
        .btn_test     (btn_test),
        .count_reset  (count_reset),
        .count_test   (count_test)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: debounced level of each button, judged on raw samples
    int cyc = 0;
    int epoch = 0;
    bit hist [6][HN];
    int run [6];
    bit ml [6];
    int hstart [2];
    int hend [2];

    function automatic bit lvl(input int b, input int n);
        if (n < epoch || n < 0 || n >= HN) return 1'b0;
        return hist[b][n];
    endfunction

    initial begin
        for (int b = 0; b < 6; b++) begin
            run[b] = 0;
            ml[b]  = 1'b0;
        end
        for (int h = 0; h < 2; h++) begin
            hstart[h] = BIG;
            hend[h]   = BIG;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                epoch = cyc + 1;
                for (int b = 0; b < 6; b++) begin
                    run[b] = 0;
                    ml[b]  = 1'b0;
                end
                for (int h = 0; h < 2; h++) begin
                    hstart[h] = BIG;
                    hend[h]   = BIG;
                end
            end else begin
                for (int b = 0; b < 6; b++) begin
                    if (raw[b] != ml[b]) run[b]++;
                    else run[b] = 0;
                    if (run[b] == DEB) begin
                        ml[b]  = raw[b];
                        run[b] = 0;
                        if (b >= 4) begin
                            if (ml[b]) begin
                                hstart[b-4] = cyc + 4;
                                hend[b-4]   = BIG;
                            end else begin
                                hend[b-4] = cyc + 3;
                            end
                        end
                    end
                    if (cyc < HN) hist[b][cyc] = ml[b];
                end
            end
        end
    end

    // Pulse log used by the hand-computed checks
    int npulse [6];
    int first [6];
    int cmax [2];

    task automatic clear_log();
        for (int i = 0; i < 6; i++) begin
            npulse[i] = 0;
            first[i]  = -1;
        end
        cmax[0] = 0;
        cmax[1] = 0;
    endtask

    initial begin
        logic [5:0] ab, eb;
        logic [2:0] ec [2];
        bit         ef [2];
        bit         act;
        bit         msk;
        int         m;
        clear_log();
        forever begin
            @(negedge clk);
            ab = {btn_test, btn_reset, btn_diversion,
                  btn_hambre, btn_energia, btn_salud};
            if (!rst_n) begin
                check("in_reset", int'({ab, count_reset, count_test}), 0);
            end else begin
                m   = cyc;
                msk = lvl(4, m - 3) | lvl(5, m - 3);
                for (int b = 0; b < 4; b++)
                    eb[b] = lvl(b, m - 4) & ~lvl(b, m - 5) & ~msk;
                for (int h = 0; h < 2; h++) begin
                    act   = (m >= hstart[h]) && (m < hend[h]);
                    ec[h] = 3'd0;
                    if (act) begin
                        if ((m - hstart[h]) / TPS >= 7) ec[h] = 3'd7;
                        else ec[h] = 3'((m - hstart[h]) / TPS);
                    end
                    ef[h] = act && (m == hstart[h] + HOLD * TPS);
                end
                eb[4] = ef[0];
                eb[5] = ef[1] & ~ef[0];
                check($sformatf("cycle%0d", m),
                      int'({ab, count_reset, count_test}),
                      int'({eb, ec[0], ec[1]}));
                for (int i = 0; i < 6; i++) begin
                    if (ab[i]) begin
                        npulse[i]++;
                        if (first[i] < 0) first[i] = m;
                    end
                end
                if (int'(count_reset) > cmax[0]) cmax[0] = int'(count_reset);
                if (int'(count_test) > cmax[1]) cmax[1] = int'(count_test);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic press(input logic [5:0] m, input int n, output int t0);
        @(negedge clk);
        #1;
        raw = m;
        t0  = cyc + 1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        raw = '0;
    endtask

    initial begin
        int t0;
        int t1;
        rst_n = 1'b0;
        raw   = '0;
        idle(3);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        @(negedge clk);
        check("reset_state",
              int'({btn_salud, btn_energia, btn_hambre, btn_diversion,
                    btn_reset, btn_test, count_reset, count_test}), 0);

        clear_log();
        press(6'b000001, 20, t0);
        idle(15);
        check("salud_pulses", npulse[IDX_SALUD], 1);
        check("salud_latency", first[IDX_SALUD] - t0, 7);
        idle(20);
        check("salud_release", npulse[IDX_SALUD], 1);

        clear_log();
        press(6'b000100, 3, t0);
        idle(20);
        check("hambre_glitch", npulse[IDX_HAMBRE], 0);
        press(6'b000100, 4, t0);
        idle(20);
        check("hambre_press4", npulse[IDX_HAMBRE], 1);
        check("hambre_latency", first[IDX_HAMBRE] - t0, 7);

        clear_log();
        press(6'b100000, 100, t0);
        idle(20);
        check("test_pulses", npulse[IDX_TEST], 1);
        check("test_fire_time", first[IDX_TEST] - t0, 57);
        check("test_saturate", cmax[1], 7);
        check("test_cleared", int'(count_test), 0);

        clear_log();
        press(6'b010000, 40, t0);
        idle(20);
        check("reset_max", cmax[0], 3);
        check("reset_nopulse", npulse[IDX_RESET], 0);
        check("reset_cleared", int'(count_reset), 0);

        clear_log();
        @(negedge clk);
        #1;
        raw = 6'b110000;
        idle(20);
        @(negedge clk);
        #1;
        raw[IDX_ENERGIA] = 1'b1;
        idle(10);
        @(negedge clk);
        #1;
        raw[IDX_ENERGIA] = 1'b0;
        idle(30);
        @(negedge clk);
        #1;
        raw = '0;
        idle(20);
        check("both_reset", npulse[IDX_RESET], 1);
        check("both_test", npulse[IDX_TEST], 0);
        check("both_energia", npulse[IDX_ENERGIA], 0);

        clear_log();
        @(negedge clk);
        #1;
        raw = 6'b011000;
        idle(35);
        @(negedge clk);
        check("pre_rst_count", int'(count_reset), 2);
        #1;
        rst_n = 1'b0;
        raw[IDX_RESET] = 1'b0;
        #1;
        check("rst_async",
              int'({btn_salud, btn_energia, btn_hambre, btn_diversion,
                    btn_reset, btn_test, count_reset, count_test}), 0);
        idle(3);
        clear_log();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        t1 = cyc + 1;
        idle(20);
        check("div_after_rst", npulse[IDX_DIVERSION], 1);
        check("div_latency", first[IDX_DIVERSION] - t1, 7);
        @(negedge clk);
        #1;
        raw = '0;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
